adc_rail_filter: RTL and testbench

ADC_RAIL_FILTER -- requirements
Module: adc_rail_filter

---
 rtl/adc_rail_filter.sv | 170 +++++++++++++++++
 tb/tb_adc_rail_filter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_rail_filter.sv
// rtl/adc_rail_filter.sv - 4-sample moving-average filter for two XADC rail channels with fill/run/stale supervision
module adc_rail_filter #(
    parameter logic [4:0]  CH_5V    = 5'd16,
    parameter logic [4:0]  CH_OTHER = 5'd17,
    parameter logic [15:0] TIMEOUT  = 16'd50000
) (
    input  logic        clk,
    input  logic        reset_in,
    input  logic [15:0] adc_data,
    input  logic [4:0]  adc_channel,
    input  logic        adc_drdy,
    output logic [11:0] volt_5v,
    output logic [11:0] volt_other,
    output logic        drdy_out,
    output logic        sample_valid,
    output logic        stale
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        fill_q, fill_d;
    logic [15:0]       stale_cnt_q, stale_cnt_d;
    logic [3:0][11:0]  hist_5v_q, hist_5v_d;
    logic [3:0][11:0]  hist_other_q, hist_other_d;
    logic [13:0]       sum_5v_q, sum_5v_d;
    logic [13:0]       sum_other_q, sum_other_d;
    logic [11:0]       volt_5v_q, volt_5v_d;
    logic [11:0]       volt_other_q, volt_other_d;
    logic              drdy_out_q, drdy_out_d;

    logic [11:0]       sample;
    logic              acc_5v;
    logic              acc_other;
    logic              timeout_hit;
    logic [13:0]       sum_5v_next;
    logic [13:0]       sum_other_next;
    logic              unused_low_bits;

    assign sample          = adc_data[15:4];
    assign unused_low_bits = ^adc_data[3:0];
    assign acc_5v          = adc_drdy && (adc_channel == CH_5V);
    assign acc_other       = adc_drdy && (adc_channel == CH_OTHER) && !acc_5v;

    // Running sums never go negative: the oldest entry is always part of the current sum.
    assign sum_5v_next    = sum_5v_q + {2'b00, sample} - {2'b00, hist_5v_q[3]};
    assign sum_other_next = sum_other_q + {2'b00, sample} - {2'b00, hist_other_q[3]};

    always_comb begin
        stale_cnt_d = stale_cnt_q;
        if (acc_5v) begin
            stale_cnt_d = 16'd0;
        end else if (stale_cnt_q < TIMEOUT) begin
            stale_cnt_d = stale_cnt_q + 16'd1;
        end
    end

    // An accepted 5 V sample always beats the timeout on the same edge.
    assign timeout_hit = !acc_5v && (stale_cnt_d == TIMEOUT);

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (acc_5v && (fill_q == 2'd3)) begin
                    state_d = ST_RUN;
                end else if (timeout_hit) begin
                    state_d = ST_STALE;
                end
            end
            ST_RUN: begin
                if (timeout_hit) begin
                    state_d = ST_STALE;
                end
            end
            ST_STALE: begin
                if (acc_5v) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_comb begin
        sample_valid = (state_q == ST_RUN);
        stale        = (state_q == ST_STALE);
    end

    always_comb begin
        fill_d       = fill_q;
        hist_5v_d    = hist_5v_q;
        hist_other_d = hist_other_q;
        sum_5v_d     = sum_5v_q;
        sum_other_d  = sum_other_q;
        volt_5v_d    = volt_5v_q;
        volt_other_d = volt_other_q;
        drdy_out_d   = 1'b0;

        if (state_q == ST_STALE) begin
            // Restart from a clean window seeded with the arriving sample; outputs stay frozen.
            if (acc_5v) begin
                hist_5v_d    = {36'd0, sample};
                sum_5v_d     = {2'b00, sample};
                hist_other_d = '0;
                sum_other_d  = 14'd0;
                fill_d       = 2'd1;
            end
        end else begin
            if (acc_5v) begin
                hist_5v_d = {hist_5v_q[2:0], sample};
                sum_5v_d  = sum_5v_next;
                volt_5v_d = sum_5v_next[13:2];
                if (state_q == ST_RUN) begin
                    drdy_out_d = 1'b1;
                end else if (fill_q == 2'd3) begin
                    drdy_out_d = 1'b1;
                end else begin
                    fill_d = fill_q + 2'd1;
                end
            end
            if (acc_other) begin
                hist_other_d = {hist_other_q[2:0], sample};
                sum_other_d  = sum_other_next;
                volt_other_d = sum_other_next[13:2];
            end
        end
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            fill_q       <= 2'd0;
            stale_cnt_q  <= 16'd0;
            hist_5v_q    <= '0;
            hist_other_q <= '0;
            sum_5v_q     <= 14'd0;
            sum_other_q  <= 14'd0;
            volt_5v_q    <= 12'd0;
            volt_other_q <= 12'd0;
            drdy_out_q   <= 1'b0;
        end else begin
            fill_q       <= fill_d;
            stale_cnt_q  <= stale_cnt_d;
            hist_5v_q    <= hist_5v_d;
            hist_other_q <= hist_other_d;
            sum_5v_q     <= sum_5v_d;
            sum_other_q  <= sum_other_d;
            volt_5v_q    <= volt_5v_d;
            volt_other_q <= volt_other_d;
            drdy_out_q   <= drdy_out_d;
        end
    end

    assign volt_5v    = volt_5v_q;
    assign volt_other = volt_other_q;
    assign drdy_out   = drdy_out_q;

endmodule

// File: tb/tb_adc_rail_filter.sv
// tb/tb_adc_rail_filter.sv - self-checking bench for adc_rail_filter against a queue-based rail model
module tb_adc_rail_filter;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] adc_data = 16'd0;
    logic [4:0]  adc_channel = 5'd0;
    logic        adc_drdy = 1'b0;
    logic [11:0] volt_5v;
    logic [11:0] volt_other;
    logic        drdy_out;
    logic        sample_valid;
    logic        stale;

    always #5 clk = ~clk;

    adc_rail_filter #(
        .CH_5V    (5'd16),
        .CH_OTHER (5'd17),
        .TIMEOUT  (16'(TO))
    ) dut (
        .clk          (clk),
        .reset_in     (rst),
        .adc_data     (adc_data),
        .adc_channel  (adc_channel),
        .adc_drdy     (adc_drdy),
        .volt_5v      (volt_5v),
        .volt_other   (volt_other),
        .drdy_out     (drdy_out),
        .sample_valid (sample_valid),
        .stale        (stale)
    );

    int ncmp = 0;
    int nfail = 0;

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0=fill, 1=run, 2=stale; windows hold the newest samples first.
    int q5[$];
    int qo[$];
    int mode = 0;
    int fills = 0;
    int idle = 0;
    int e_v5 = 0;
    int e_vo = 0;
    int e_drdy = 0;
    int d;
    bit a5;
    bit ao;

    function automatic int window_avg(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return s / 4;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q5.delete(); qo.delete();
            mode = 0; fills = 0; idle = 0;
            e_v5 = 0; e_vo = 0; e_drdy = 0;
        end else begin
            d  = int'(adc_data >> 4);
            a5 = adc_drdy && adc_channel == 5'd16;
            ao = adc_drdy && adc_channel == 5'd17;
            e_drdy = 0;
            if (mode == 2) begin
                if (a5) begin
                    q5.delete(); qo.delete();
                    q5.push_front(d);
                    fills = 1; mode = 0; idle = 0;
                end
            end else begin
                if (a5) begin
                    q5.push_front(d);
                    if (q5.size() > 4) void'(q5.pop_back());
                    e_v5 = window_avg(q5);
                    idle = 0;
                    if (mode == 1) e_drdy = 1;
                    else if (fills == 3) begin mode = 1; e_drdy = 1; end
                    else fills++;
                end else begin
                    if (idle < TO) idle++;
                    if (idle == TO) mode = 2;
                end
                if (ao) begin
                    qo.push_front(d);
                    if (qo.size() > 4) void'(qo.pop_back());
                    e_vo = window_avg(qo);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("volt_5v", int'(volt_5v), e_v5);
            chk("volt_other", int'(volt_other), e_vo);
            chk("drdy_out", int'(drdy_out), e_drdy);
            chk("sample_valid", int'(sample_valid), int'(mode == 1));
            chk("stale", int'(stale), int'(mode == 2));
        end
    end

    task automatic send(input logic [4:0] ch, input int v);
        adc_drdy    = 1'b1;
        adc_channel = ch;
        adc_data    = {v[11:0], 4'($urandom_range(0, 15))};
        @(posedge clk);
        #1;
        adc_drdy = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        adc_drdy = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse_check(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_v5"}, int'(volt_5v), 0);
        chk({tag, "_vo"}, int'(volt_other), 0);
        chk({tag, "_drdy"}, int'(drdy_out), 0);
        chk({tag, "_valid"}, int'(sample_valid), 0);
        chk({tag, "_stale"}, int'(stale), 0);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(negedge clk);
        chk("rst_v5", int'(volt_5v), 0);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_stale", int'(stale), 0);
        chk("rst_drdy", int'(drdy_out), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            send(5'd16, 3150);
            chk("fill_no_drdy", int'(drdy_out), 0);
        end
        send(5'd16, 3150);
        chk("fill4_drdy", int'(drdy_out), 1);
        chk("fill4_valid", int'(sample_valid), 1);
        chk("fill4_v5", int'(volt_5v), 3150);
        chk("model_fill4_v5", e_v5, 3150);

        send(5'd16, 3250);
        chk("run_3250_v5", int'(volt_5v), 3175);
        chk("run_3250_drdy", int'(drdy_out), 1);
        send(5'd16, 3101);
        chk("run_3101_v5", int'(volt_5v), 3162);
        chk("model_3101_v5", e_v5, 3162);

        for (int i = 0; i < 4; i++) begin
            send(5'd17, 3000);
            chk("other_drdy", int'(drdy_out), 0);
            send(5'd3, int'($urandom_range(0, 4095)));
            chk("ch3_drdy", int'(drdy_out), 0);
            chk("ch3_v5_held", int'(volt_5v), 3162);
        end
        chk("other_conv", int'(volt_other), 3000);

        send(5'd16, 3200);
        chk("pre_edge_v5", int'(volt_5v), 3175);
        idle_cycles(TO - 1);
        chk("edge_not_stale_yet", int'(stale), 0);
        send(5'd16, 3300);
        chk("edge_sample_wins_stale", int'(stale), 0);
        chk("edge_sample_wins_drdy", int'(drdy_out), 1);
        chk("edge_v5", int'(volt_5v), 3212);

        idle_cycles(TO - 1);
        chk("pre_timeout_stale", int'(stale), 0);
        idle_cycles(1);
        chk("timeout_stale", int'(stale), 1);
        chk("timeout_valid", int'(sample_valid), 0);
        chk("timeout_v5_held", int'(volt_5v), 3212);
        send(5'd17, 500);
        chk("stale_vo_held", int'(volt_other), 3000);
        send(5'd16, 4000);
        chk("reload_stale", int'(stale), 0);
        chk("reload_drdy", int'(drdy_out), 0);
        chk("reload_v5_held", int'(volt_5v), 3212);
        send(5'd16, 4000);
        chk("refill2_drdy", int'(drdy_out), 0);
        send(5'd16, 4000);
        chk("refill3_drdy", int'(drdy_out), 0);
        send(5'd16, 4000);
        chk("refill4_drdy", int'(drdy_out), 1);
        chk("refill4_v5", int'(volt_5v), 4000);

        send(5'd16, 1234);
        send(5'd16, 2345);
        reset_pulse_check("async_rst");
        send(5'd16, 1000);
        chk("post_rst1_drdy", int'(drdy_out), 0);
        send(5'd16, 2000);
        send(5'd16, 3000);
        chk("post_rst3_drdy", int'(drdy_out), 0);
        send(5'd16, 4000);
        chk("post_rst4_drdy", int'(drdy_out), 1);
        chk("post_rst4_v5", int'(volt_5v), 2500);

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                idle_cycles(int'($urandom_range(TO - 2, TO + 20)));
            end else if (r < 3) begin
                reset_pulse_check("rand_rst");
            end else begin
                int c;
                c = int'($urandom_range(0, 3));
                adc_drdy    = ($urandom_range(0, 3) != 0);
                adc_channel = (c == 0) ? 5'd16 : (c == 1) ? 5'd17 : (c == 2) ? 5'd3 : 5'($urandom_range(0, 31));
                adc_data    = 16'($urandom());
                @(posedge clk);
                #1;
            end
        end
        adc_drdy = 1'b0;
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
